// File: rtl/reset_sequencer.sv
// Reset root: synchronizes rst_in deassertion, holds, then releases rst_out[0..N_OUT-1] in order.
// Release of bit k lands N_STAGE+1+HOLD_CYCLES+k*STEP_CYCLES edges after rst_in is first sampled low.
module reset_sequencer #(
    parameter int N_STAGE     = 4,
    parameter int N_OUT       = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STEP_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             sw_rst_req,
    output logic [N_OUT-1:0] rst_out,
    output logic             seq_done
);

    localparam int MAX_CNT = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int IDX_W   = $clog2(N_OUT + 1);

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    logic [N_STAGE-1:0] r_sync;
    logic               w_rst_sync;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [N_OUT-1:0]   r_rst_out, w_rst_out_nxt;
    logic               r_done, w_done_nxt;

    // Deassertion-only synchronizer: every stage is set asynchronously by rst_in.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[N_STAGE-2:0], 1'b0};
        end
    end

    assign w_rst_sync = r_sync[N_STAGE-1];

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            r_state   <= ST_RESET;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_rst_out <= '1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_rst_out <= w_rst_out_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_idx;
        w_rst_out_nxt = r_rst_out;
        w_done_nxt    = r_done;

        case (r_state)
            ST_RESET: begin
                if (!w_rst_sync) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = '0;
                end
            end

            ST_HOLD: begin
                if (sw_rst_req) begin
                    w_state_nxt   = ST_HOLD;
                    w_cnt_nxt     = '0;
                    w_idx_nxt     = '0;
                    w_rst_out_nxt = '1;
                    w_done_nxt    = 1'b0;
                end else if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                    w_rst_out_nxt[0] = 1'b0;
                    w_cnt_nxt        = '0;
                    w_idx_nxt        = IDX_W'(1);
                    if (N_OUT == 1) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_RELEASE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            ST_RELEASE: begin
                if (sw_rst_req) begin
                    w_state_nxt   = ST_HOLD;
                    w_cnt_nxt     = '0;
                    w_idx_nxt     = '0;
                    w_rst_out_nxt = '1;
                    w_done_nxt    = 1'b0;
                end else if (r_cnt == CNT_W'(STEP_CYCLES - 1)) begin
                    // Only the bit at r_idx may clear, which keeps release strictly in index order.
                    for (int k = 0; k < N_OUT; k++) begin
                        if (r_idx == IDX_W'(k)) begin
                            w_rst_out_nxt[k] = 1'b0;
                        end
                    end
                    w_cnt_nxt = '0;
                    w_idx_nxt = r_idx + IDX_W'(1);
                    if (r_idx == IDX_W'(N_OUT - 1)) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            ST_DONE: begin
                if (sw_rst_req) begin
                    w_state_nxt   = ST_HOLD;
                    w_cnt_nxt     = '0;
                    w_idx_nxt     = '0;
                    w_rst_out_nxt = '1;
                    w_done_nxt    = 1'b0;
                end
            end

            default: begin
                w_state_nxt = ST_RESET;
            end
        endcase
    end

    assign rst_out  = r_rst_out;
    assign seq_done = r_done;

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Single-clock reset synchronizer and ordered reset releaser. `rst_in` is an asynchronous master reset. Asserting it drives all outputs into reset immediately. Deassertion passes through an `N_STAGE` synchronizer, then a hold window, then releases `N_OUT` downstream resets one at a time in index order, a fixed step apart. A synchronous software reset request reruns the hold-and-release sequence without the synchronizer delay. It sits at the root of each clock domain's reset tree, for example FIFO write/read pointer logic and downstream datapaths.

## Interface
- `N_STAGE`, default 4: synchronizer depth. Legal range ≥ 2.
- `N_OUT`, default 4: number of sequenced reset outputs. Legal range 1..16.
- `HOLD_CYCLES`, default 16: cycles between the synchronized release and the release of `rst_out[0]`. Must be ≥ 1.
- `STEP_CYCLES`, default 8: cycles between consecutive output releases. Must be ≥ 1.
- `clk` in 1: clock.
- `rst_in` in 1: reset, asynchronous, active-high. Clock is `clk`.
- `sw_rst_req` in 1: software reset request. Synchronous to `clk`, active-high, level-sampled.
- `rst_out` out `N_OUT`: active-high resets. Bit k is released k-th.
- `seq_done` out 1: high once all `rst_out` bits are released.

## Operation
- **Synchronizer:** `N_STAGE` flops, all set asynchronously by `rst_in`. Stage 0 loads 0; each later stage loads the previous one. `rst_sync` is the last stage.
- **Reset scope:** every sequencer flop (state, counter, index, `rst_out`, `seq_done`) is asynchronously reset by `rst_in`.
  - Reset values: `rst_out` = all ones, `seq_done` = 0, state = RESET, counter = 0, index = 0.
- **FSM states:** RESET, HOLD, RELEASE, DONE.
- **Transitions:**
  - RESET: when `rst_sync` = 0, go to HOLD with counter = 0.
  - HOLD: counter increments each cycle. On the edge where counter = `HOLD_CYCLES`−1:
    - clear `rst_out[0]`, counter = 0, index = 1;
    - go to RELEASE, or go to DONE and set `seq_done` = 1 if `N_OUT` = 1.
  - RELEASE: counter increments each cycle. On the edge where counter = `STEP_CYCLES`−1:
    - clear `rst_out[index]`, counter = 0, index + 1;
    - if index was `N_OUT`−1, go to DONE and set `seq_done` = 1 on the same edge.
  - DONE: outputs hold.
- **Software reset:** if `sw_rst_req` = 1 on an edge in HOLD, RELEASE or DONE:
  - `rst_out` = all ones, `seq_done` = 0, state = HOLD, counter = 0, index = 0.
  - Holding the request high keeps restarting HOLD, so outputs stay asserted.
  - `sw_rst_req` is ignored in RESET.
- **Priority:** `rst_in` > `sw_rst_req` > normal sequencing.
- **Bit monotonicity:** a `rst_out` bit never deasserts out of index order. Once cleared, it re-asserts only via `rst_in` or `sw_rst_req`.
- **Counter width:** `$clog2(max(HOLD_CYCLES, STEP_CYCLES)+1)`. The counter never wraps, because it is cleared at each terminal count.

## Timing
- **Assertion:** `rst_in` rising forces `rst_out` to all ones and `seq_done` to 0 combinationally through the async set/clear, with no clock needed. This includes a `rst_in` pulse mid-sequence, which fully restarts the sequence.
- **Deassertion:** number edges from E1, the first rising edge at which `rst_in` is sampled low.
  - `rst_sync` falls at edge `N_STAGE`.
  - FSM enters HOLD at edge `N_STAGE`+1.
  - `rst_out[k]` falls at edge `N_STAGE`+1+`HOLD_CYCLES`+k·`STEP_CYCLES`.
  - `seq_done` rises on the same edge as `rst_out[N_OUT−1]`.
- **Software reset:** let S be the last edge sampling `sw_rst_req` = 1.
  - Outputs re-assert at the first sampled edge.
  - `rst_out[k]` falls at edge S+`HOLD_CYCLES`+k·`STEP_CYCLES`.
- **Outputs:** all outputs are registered, with no combinational path from `sw_rst_req`.

## Test plan
- **Defaults, `rst_in` high 3 cycles then low at E1:** `rst_out[0..3]` fall at edges 21, 29, 37, 45; `seq_done` rises at edge 45.
- **`rst_in` pulsed high between clock edges during RELEASE, after `rst_out[1]` is released:** `rst_out` reads 4'b1111 and `seq_done` 0 before the next edge; after `rst_in` falls, the full timeline of 21/29/37/45 repeats from the new E1.
- **DONE, `sw_rst_req` pulsed 1 cycle at edge S:** `rst_out` = 4'b1111 after S; bits fall at S+16, S+24, S+32, S+40; `seq_done` rises at S+40.
- **`sw_rst_req` held high for 5 edges during HOLD:** outputs stay asserted; release times are counted from the 5th edge; `sw_rst_req` asserted in RESET has no effect on the timeline.
- **`N_OUT`=1, `HOLD_CYCLES`=1, `STEP_CYCLES`=1, `N_STAGE`=2:** `rst_out[0]` and `seq_done` change at edge 4.
- **`N_OUT`=16, `STEP_CYCLES`=1:** the bits release on consecutive edges in strict index order, never two in one cycle.
